// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern and overlap/non-overlap mode.
// It also keeps a saturating match counter and a sticky saturation flag. All outputs are registered.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             X,
  input  logic             X_VALID,
  input  logic             LOAD,
  input  logic [PAT_W-1:0] PATTERN,
  input  logic             OVERLAP,
  output logic             DET,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic             CNT_SAT
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  pat_reg;
  logic              ovl_reg;
  // Only PAT_W-1 past bits are kept: the incoming X completes the window.
  logic [PAT_W-2:0]  hist_reg;
  logic [FILL_W-1:0] fill_reg;
  logic              det_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              sat_reg;

  logic [PAT_W-1:0]  window_next;
  logic              match_next;
  logic [CNT_W-1:0]  cnt_next;

  always_comb begin
    window_next = {hist_reg, X};
    match_next  = X_VALID && (window_next == pat_reg) && (fill_reg >= FILL_ARM);
    cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  end

  // The fill counter is the detector state: FILL(0..PAT_W-1), then ARMED at PAT_W.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      pat_reg  <= '0;
      ovl_reg  <= 1'b0;
      hist_reg <= '0;
      fill_reg <= '0;
      det_reg  <= 1'b0;
      cnt_reg  <= '0;
      sat_reg  <= 1'b0;
    end else if (LOAD) begin
      pat_reg  <= PATTERN;
      ovl_reg  <= OVERLAP;
      hist_reg <= '0;
      fill_reg <= '0;
      det_reg  <= 1'b0;
      cnt_reg  <= '0;
      sat_reg  <= 1'b0;
    end else begin
      det_reg <= match_next;
      if (X_VALID) begin
        hist_reg <= window_next[PAT_W-2:0];
        if (match_next && !ovl_reg)
          fill_reg <= '0;
        else if (fill_reg != FILL_FULL)
          fill_reg <= fill_reg + 1'b1;
      end
      if (match_next) begin
        cnt_reg <= cnt_next;
        if (cnt_next == CNT_MAX)
          sat_reg <= 1'b1;
      end
    end
  end

  assign DET       = det_reg;
  assign MATCH_CNT = cnt_reg;
  assign CNT_SAT   = sat_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Table-driven bench for seq_detector_param (default widths) plus a hand-written
// saturation sequence on a second instance with a 2-bit match counter.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: PAT_W=4, CNT_W=8
  logic       a_clr, a_x, a_xv, a_load, a_ovl;
  logic [3:0] a_pat;
  logic       a_det, a_sat;
  logic [7:0] a_cnt;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut_a (
    .CLK(clk), .CLR(a_clr), .X(a_x), .X_VALID(a_xv), .LOAD(a_load),
    .PATTERN(a_pat), .OVERLAP(a_ovl), .DET(a_det), .MATCH_CNT(a_cnt), .CNT_SAT(a_sat)
  );

  // Instance B: PAT_W=4, CNT_W=2
  logic       b_clr, b_x, b_xv, b_load, b_ovl;
  logic [3:0] b_pat;
  logic       b_det, b_sat;
  logic [1:0] b_cnt;

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut_b (
    .CLK(clk), .CLR(b_clr), .X(b_x), .X_VALID(b_xv), .LOAD(b_load),
    .PATTERN(b_pat), .OVERLAP(b_ovl), .DET(b_det), .MATCH_CNT(b_cnt), .CNT_SAT(b_sat)
  );

  typedef struct {
    string      name;
    logic       clr;
    logic       load;
    logic [3:0] pat;
    logic       ovl;
    logic       xv;
    logic       x;
    logic       det;
    logic [7:0] cnt;
    logic       sat;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string name, input logic clr, input logic load, input logic [3:0] pat,
                     input logic ovl, input logic xv, input logic x,
                     input logic det, input logic [7:0] cnt, input logic sat);
    vec_t v;
    v.name = name; v.clr = clr; v.load = load; v.pat = pat; v.ovl = ovl;
    v.xv = xv; v.x = x; v.det = det; v.cnt = cnt; v.sat = sat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle on instance B and compare its outputs just after the edge.
  task automatic step_b(input string name, input logic clr, input logic load, input logic [3:0] pat,
                        input logic ovl, input logic xv, input logic x,
                        input logic det, input logic [1:0] cnt, input logic sat);
    b_clr = clr; b_load = load; b_pat = pat; b_ovl = ovl; b_xv = xv; b_x = x;
    @(posedge clk); #1;
    check({name, ".det"}, int'(b_det), int'(det));
    check({name, ".cnt"}, int'(b_cnt), int'(cnt));
    check({name, ".sat"}, int'(b_sat), int'(sat));
    $display("B %-10s det=%0b cnt=%0d sat=%0b", name, b_det, b_cnt, b_sat);
  endtask

  initial begin
    a_clr = 1'b1; a_load = 1'b0; a_pat = '0; a_ovl = 1'b0; a_xv = 1'b0; a_x = 1'b0;
    b_clr = 1'b1; b_load = 1'b0; b_pat = '0; b_ovl = 1'b0; b_xv = 1'b0; b_x = 1'b0;

    //   name        clr load pat   ovl xv x   det cnt sat
    add("rst0",      1, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("rst1",      1, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("load_ov",   0, 1, 4'hB, 1, 0, 0,  0, 0, 0);
    // overlap stream 1,0,1,1,0,1,1 (PATTERN input garbage: must be ignored)
    add("ov_b1",     0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("ov_b2",     0, 0, 4'h0, 0, 1, 0,  0, 0, 0);
    add("ov_b3",     0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("ov_b4",     0, 0, 4'h0, 0, 1, 1,  1, 1, 0);
    add("ov_b5",     0, 0, 4'h0, 0, 1, 0,  0, 1, 0);
    add("ov_b6",     0, 0, 4'h0, 0, 1, 1,  0, 1, 0);
    add("ov_b7",     0, 0, 4'h0, 0, 1, 1,  1, 2, 0);
    add("ov_idle",   0, 0, 4'h0, 0, 0, 1,  0, 2, 0);
    // non-overlap, same stream
    add("load_no",   0, 1, 4'hB, 0, 0, 0,  0, 0, 0);
    add("no_b1",     0, 0, 4'h5, 1, 1, 1,  0, 0, 0);
    add("no_b2",     0, 0, 4'h5, 1, 1, 0,  0, 0, 0);
    add("no_b3",     0, 0, 4'h5, 1, 1, 1,  0, 0, 0);
    add("no_b4",     0, 0, 4'h5, 1, 1, 1,  1, 1, 0);
    add("no_b5",     0, 0, 4'h5, 1, 1, 0,  0, 1, 0);
    add("no_b6",     0, 0, 4'h5, 1, 1, 1,  0, 1, 0);
    add("no_b7",     0, 0, 4'h5, 1, 1, 1,  0, 1, 0);
    // idle gaps inside the pattern
    add("load_gap",  0, 1, 4'hB, 1, 0, 0,  0, 0, 0);
    add("gap_b1",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("gap_b2",    0, 0, 4'h0, 0, 1, 0,  0, 0, 0);
    add("gap_i1",    0, 0, 4'h0, 0, 0, 1,  0, 0, 0);
    add("gap_i2",    0, 0, 4'h0, 0, 0, 1,  0, 0, 0);
    add("gap_i3",    0, 0, 4'h0, 0, 0, 1,  0, 0, 0);
    add("gap_b3",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("gap_b4",    0, 0, 4'h0, 0, 1, 1,  1, 1, 0);
    // LOAD mid-stream discards the coincident bit and the partial match
    add("load_mid",  0, 1, 4'hB, 1, 0, 0,  0, 0, 0);
    add("mid_b1",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("mid_b2",    0, 0, 4'h0, 0, 1, 0,  0, 0, 0);
    add("mid_b3",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("mid_load",  0, 1, 4'hB, 1, 1, 1,  0, 0, 0);
    add("mid_b4",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("mid_b5",    0, 0, 4'h0, 0, 1, 0,  0, 0, 0);
    add("mid_b6",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("mid_b7",    0, 0, 4'h0, 0, 1, 1,  1, 1, 0);
    // CLR mid-pattern clears pattern to 0000, non-overlap
    add("clr_b1",    0, 0, 4'h0, 0, 1, 1,  0, 1, 0);
    add("clr_b2",    0, 0, 4'h0, 0, 1, 0,  0, 1, 0);
    add("clr_b3",    0, 0, 4'h0, 0, 1, 1,  0, 1, 0);
    add("clr_mid",   1, 0, 4'hB, 1, 1, 1,  0, 0, 0);
    add("z_b1",      0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    add("z_b2",      0, 0, 4'h0, 0, 1, 0,  0, 0, 0);
    add("z_b3",      0, 0, 4'h0, 0, 1, 0,  0, 0, 0);
    add("z_b4",      0, 0, 4'h0, 0, 1, 0,  0, 0, 0);
    add("z_b5",      0, 0, 4'h0, 0, 1, 0,  1, 1, 0);
    add("z_b6",      0, 0, 4'h0, 0, 1, 0,  0, 1, 0);

    foreach (vecs[i]) begin
      a_clr = vecs[i].clr; a_load = vecs[i].load; a_pat = vecs[i].pat;
      a_ovl = vecs[i].ovl; a_xv = vecs[i].xv; a_x = vecs[i].x;
      @(posedge clk); #1;
      check({vecs[i].name, ".det"}, int'(a_det), int'(vecs[i].det));
      check({vecs[i].name, ".cnt"}, int'(a_cnt), int'(vecs[i].cnt));
      check({vecs[i].name, ".sat"}, int'(a_sat), int'(vecs[i].sat));
      $display("A %-10s det=%0b cnt=%0d sat=%0b", vecs[i].name, a_det, a_cnt, a_sat);
    end

    // Saturation on the 2-bit counter: matches on bits 4..8 read 1,2,3,3,3
    step_b("s_rst",   1, 0, 4'h0, 0, 0, 0,  0, 0, 0);
    step_b("s_load",  0, 1, 4'hF, 1, 0, 0,  0, 0, 0);
    step_b("s_b1",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    step_b("s_b2",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    step_b("s_b3",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);
    step_b("s_b4",    0, 0, 4'h0, 0, 1, 1,  1, 1, 0);
    step_b("s_b5",    0, 0, 4'h0, 0, 1, 1,  1, 2, 0);
    step_b("s_b6",    0, 0, 4'h0, 0, 1, 1,  1, 3, 1);
    step_b("s_b7",    0, 0, 4'h0, 0, 1, 1,  1, 3, 1);
    step_b("s_b8",    0, 0, 4'h0, 0, 1, 1,  1, 3, 1);
    step_b("s_idle",  0, 0, 4'h0, 0, 0, 1,  0, 3, 1);
    step_b("s_load2", 0, 1, 4'hF, 1, 1, 1,  0, 0, 0);
    step_b("s_c1",    0, 0, 4'h0, 0, 1, 1,  0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
